forwarding_scoreboard: RTL and testbench
========================================

Name: forwarding_scoreboard

Overview:
- Parametrised successor to the decode-to-execute operand bypass. Adds a per-register scoreboard that tracks in-flight writes with variable result latency (ALU, load, multi-cycle units).
- Sits between decode and execute. Stalls issue on RAW/WAW hazards that bypass cannot cover, and forwards the result that is being written back in the current cycle.
- Also provides flush handling, a sticky latency-overrun error and a stall performance counter.

Parameters:
- DATA_WIDTH, 32, width of register values and the writeback bus.
- REG_COUNT, 32, number of architectural registers; register 0 is hard-wired zero and is never tracked.
- LAT_WIDTH, 3, width of the latency field; maximum declared latency is 2**LAT_WIDTH-1.
- CNT_WIDTH, 32, width of the stall performance counter.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- issue_valid  in  1  decode presents an instruction.
- issue_ready  out  1  instruction may enter execute this cycle.
- issue_rs1, issue_rs2  in  $clog2(REG_COUNT)  source register indices.
- issue_rs1_used, issue_rs2_used  in  1  source operand is actually read by the opcode.
- issue_rs1_value, issue_rs2_value  in  DATA_WIDTH  register-file values.
- issue_rd  in  $clog2(REG_COUNT)  destination index.
- issue_rd_we  in  1  instruction writes rd.
- issue_latency  in  LAT_WIDTH  cycles until the result appears on the writeback bus (1 to max).
- wb_valid  in  1  writeback bus carries a result.
- wb_rd  in  $clog2(REG_COUNT)  writeback destination.
- wb_data  in  DATA_WIDTH  writeback value.
- flush  in  1  pipeline flush; discards all in-flight tracking.
- rs1_value, rs2_value  out  DATA_WIDTH  operands to execute (forwarded or register-file).
- rs1_forwarded, rs2_forwarded  out  1  operand taken from the writeback bus.
- overrun_error  out  1  sticky: a tracked write exceeded its declared latency.
- stall_count  out  CNT_WIDTH  number of cycles with issue_valid=1 and issue_ready=0.

Behaviour:
- State: per register r (1..REG_COUNT-1), a busy[r] bit and a cnt[r] down-counter of LAT_WIDTH bits. Reset clears all busy/cnt, overrun_error=0, stall_count=0. Outputs rs*_value/rs*_forwarded are combinational.
- wb_hit(x) = wb_valid && wb_rd==x && x!=0.
- Forwarding (combinational):
  - rsN_value = wb_data when rsN_used && wb_hit(rsN); otherwise issue_rsN_value.
  - rsN_forwarded mirrors the forward condition.
  - Index 0 always yields issue_rsN_value.
- RAW stall: rsN_used && busy[rsN] && !wb_hit(rsN).
- WAW stall: issue_rd_we && rd!=0 && busy[rd] && !wb_hit(rd).
- issue_ready = !(RAW1 || RAW2 || WAW) && !flush. It depends only on state and the current inputs, with no combinational path from issue_valid.
- Accept = issue_valid && issue_ready. On accept with rd_we && rd!=0: busy[rd]<=1, cnt[rd]<=issue_latency.
- Writeback: wb_hit(r) clears busy[r] next cycle, unless the same cycle accepts an issue to r, in which case the issue wins (busy=1, cnt=new latency).
- Countdown: each cycle busy[r] && cnt[r]!=0 decrements cnt[r]. If busy[r] && cnt[r]==0 && !wb_hit(r): overrun_error<=1 (sticky until reset) and busy[r] stays set.
- issue_latency==0 is illegal. It is treated as 1.
- flush: next cycle all busy/cnt are cleared; issue_ready=0 during the flush cycle. A wb in the flush cycle is still forwarded combinationally but does not matter.
- stall_count increments when issue_valid && !issue_ready, including flush cycles. It saturates at all-ones.
- Scoreboard updates take effect the cycle after accept: an instruction issued in cycle t blocks dependents from cycle t+1.
- Mid-operation reset asynchronously clears all state. issue_ready follows the cleared state immediately.

Test Plan:
- Back-to-back dependence on a 1-cycle ALU op:
  - Issue add x5 (latency 1) at t0; at t1 issue reads x5 -> issue_ready=0.
  - At t1 drive wb_valid, wb_rd=5, wb_data=0x1234 -> issue_ready=1, rs1_value=0x1234, rs1_forwarded=1.
- Load-use with latency 3:
  - Issue ld x7 at t0; dependent held with issue_ready=0 for t1..t2.
  - wb at t3 -> forwarded at t3; stall_count=2.
- WAW and x0:
  - Issue to x9 while x9 busy -> stall until wb x9.
  - Writes/reads of x0 never stall or forward (rs1=0, wb_rd=0 -> rs1_value=issue_rs1_value).
- Unused operand: rs2_used=0 with rs2 busy -> issue_ready=1, rs2_forwarded=0.
- Flush and overrun:
  - Issue x3 latency 2, flush at t1 -> at t2 reading x3 does not stall.
  - Separately, issue x4 latency 1 with no wb for 2 cycles -> overrun_error=1 and stays 1.
- Reset: assert rst asynchronously with several registers busy -> busy cleared, issue_ready=1, stall_count=0, overrun_error=0 before the next clock edge.

Source files
------------

// File: rtl/forwarding_scoreboard.sv
// Decode-to-execute operand bypass with a per-register in-flight write scoreboard.
// Stalls RAW/WAW hazards the writeback bus cannot cover and flags late results.
module forwarding_scoreboard #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_COUNT  = 32,
  parameter int LAT_WIDTH  = 3,
  parameter int CNT_WIDTH  = 32,
  localparam int IDX_W     = $clog2(REG_COUNT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  logic [IDX_W-1:0]      issue_rs1,
  input  logic [IDX_W-1:0]      issue_rs2,
  input  logic                  issue_rs1_used,
  input  logic                  issue_rs2_used,
  input  logic [DATA_WIDTH-1:0] issue_rs1_value,
  input  logic [DATA_WIDTH-1:0] issue_rs2_value,
  input  logic [IDX_W-1:0]      issue_rd,
  input  logic                  issue_rd_we,
  input  logic [LAT_WIDTH-1:0]  issue_latency,
  input  logic                  wb_valid,
  input  logic [IDX_W-1:0]      wb_rd,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] rs1_value,
  output logic [DATA_WIDTH-1:0] rs2_value,
  output logic                  rs1_forwarded,
  output logic                  rs2_forwarded,
  output logic                  overrun_error,
  output logic [CNT_WIDTH-1:0]  stall_count
);

  logic [REG_COUNT-1:0] r_busy;
  logic [LAT_WIDTH-1:0] r_cnt [REG_COUNT];
  logic                 r_overrun;
  logic [CNT_WIDTH-1:0] r_stall_count;

  logic                 w_hit_rs1, w_hit_rs2, w_hit_rd;
  logic                 w_raw1, w_raw2, w_waw;
  logic                 w_alloc;
  logic [LAT_WIDTH-1:0] w_lat;
  logic [REG_COUNT-1:0] w_wb_dec;
  logic [REG_COUNT-1:0] w_cnt_zero;

  assign w_hit_rs1 = wb_valid && (wb_rd == issue_rs1) && (issue_rs1 != '0);
  assign w_hit_rs2 = wb_valid && (wb_rd == issue_rs2) && (issue_rs2 != '0);
  assign w_hit_rd  = wb_valid && (wb_rd == issue_rd)  && (issue_rd  != '0);

  assign rs1_forwarded = issue_rs1_used && w_hit_rs1;
  assign rs2_forwarded = issue_rs2_used && w_hit_rs2;
  assign rs1_value     = rs1_forwarded ? wb_data : issue_rs1_value;
  assign rs2_value     = rs2_forwarded ? wb_data : issue_rs2_value;

  // Register 0 is never marked busy, so busy lookups need no x0 guard.
  assign w_raw1 = issue_rs1_used && r_busy[issue_rs1] && !w_hit_rs1;
  assign w_raw2 = issue_rs2_used && r_busy[issue_rs2] && !w_hit_rs2;
  assign w_waw  = issue_rd_we && (issue_rd != '0) && r_busy[issue_rd] && !w_hit_rd;

  assign issue_ready = !(w_raw1 || w_raw2 || w_waw) && !flush;
  assign w_alloc     = issue_valid && issue_ready && issue_rd_we && (issue_rd != '0);
  assign w_lat       = (issue_latency == '0) ? LAT_WIDTH'(1) : issue_latency;

  always_comb begin
    w_wb_dec   = '0;
    w_cnt_zero = '0;
    for (int r = 1; r < REG_COUNT; r++) begin
      w_wb_dec[r]   = wb_valid && (wb_rd == IDX_W'(r));
      w_cnt_zero[r] = (r_cnt[r] == '0);
    end
  end

  // NOTE: the counter array is small, so it is reset along with the busy
  // bits; this keeps cnt well defined for every register out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
      for (int r = 0; r < REG_COUNT; r++) r_cnt[r] <= '0;
    end else begin
      for (int r = 1; r < REG_COUNT; r++) begin
        if (flush) begin
          r_busy[r] <= 1'b0;
          r_cnt[r]  <= '0;
        end else if (w_alloc && (issue_rd == IDX_W'(r))) begin
          // A new issue to r beats a same-cycle writeback of the old value.
          r_busy[r] <= 1'b1;
          r_cnt[r]  <= w_lat;
        end else if (r_busy[r]) begin
          if (w_wb_dec[r]) begin
            r_busy[r] <= 1'b0;
            r_cnt[r]  <= '0;
          end else if (!w_cnt_zero[r]) begin
            r_cnt[r] <= r_cnt[r] - LAT_WIDTH'(1);
          end
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overrun     <= 1'b0;
      r_stall_count <= '0;
    end else begin
      if (|(r_busy & w_cnt_zero & ~w_wb_dec)) r_overrun <= 1'b1;
      if (issue_valid && !issue_ready && !(&r_stall_count))
        r_stall_count <= r_stall_count + CNT_WIDTH'(1);
    end
  end

  assign overrun_error = r_overrun;
  assign stall_count   = r_stall_count;

endmodule

// File: tb/tb_forwarding_scoreboard.sv
// Scoreboard bench: a timestamp-based reference model predicts each cycle's
// outputs into a queue; a negedge monitor pops and compares.
module tb_forwarding_scoreboard;

  localparam int DW = 32;
  localparam int RC = 32;
  localparam int LW = 3;
  localparam int CW = 4;
  localparam int IW = 5;

  typedef struct packed {
    logic          valid;
    logic [IW-1:0] rs1;
    logic [IW-1:0] rs2;
    logic          u1;
    logic          u2;
    logic [DW-1:0] v1;
    logic [DW-1:0] v2;
    logic [IW-1:0] rd;
    logic          we;
    logic [LW-1:0] lat;
    logic          wbv;
    logic [IW-1:0] wbrd;
    logic [DW-1:0] wdata;
    logic          flush;
  } stim_t;

  typedef struct packed {
    logic          ready;
    logic [DW-1:0] v1;
    logic [DW-1:0] v2;
    logic          f1;
    logic          f2;
    logic          ovr;
    logic [CW-1:0] stall;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  stim_t cur = '0;

  logic          issue_ready, rs1_forwarded, rs2_forwarded, overrun_error;
  logic [DW-1:0] rs1_value, rs2_value;
  logic [CW-1:0] stall_count;

  always #5 clk = ~clk;

  forwarding_scoreboard #(
    .DATA_WIDTH(DW), .REG_COUNT(RC), .LAT_WIDTH(LW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .issue_valid(cur.valid), .issue_ready(issue_ready),
    .issue_rs1(cur.rs1), .issue_rs2(cur.rs2),
    .issue_rs1_used(cur.u1), .issue_rs2_used(cur.u2),
    .issue_rs1_value(cur.v1), .issue_rs2_value(cur.v2),
    .issue_rd(cur.rd), .issue_rd_we(cur.we), .issue_latency(cur.lat),
    .wb_valid(cur.wbv), .wb_rd(cur.wbrd), .wb_data(cur.wdata),
    .flush(cur.flush),
    .rs1_value(rs1_value), .rs2_value(rs2_value),
    .rs1_forwarded(rs1_forwarded), .rs2_forwarded(rs2_forwarded),
    .overrun_error(overrun_error), .stall_count(stall_count)
  );

  // Reference model: a pending write is a (busy, due-cycle) pair per register.
  bit [RC-1:0] m_busy;
  longint      m_due [RC];
  longint      m_cyc = 0;
  bit          m_ovr;
  int          m_stall;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic hit(input stim_t s, input logic [IW-1:0] x);
    return s.wbv && (s.wbrd == x) && (x != '0);
  endfunction

  function automatic exp_t predict(input stim_t s);
    exp_t e;
    logic blocked;
    e.f1 = s.u1 && hit(s, s.rs1);
    e.f2 = s.u2 && hit(s, s.rs2);
    e.v1 = e.f1 ? s.wdata : s.v1;
    e.v2 = e.f2 ? s.wdata : s.v2;
    blocked = (s.u1 && m_busy[s.rs1] && !hit(s, s.rs1)) ||
              (s.u2 && m_busy[s.rs2] && !hit(s, s.rs2)) ||
              (s.we && s.rd != '0 && m_busy[s.rd] && !hit(s, s.rd)) ||
              s.flush;
    e.ready = !blocked;
    e.ovr   = m_ovr;
    e.stall = CW'(m_stall);
    return e;
  endfunction

  task automatic model_reset();
    m_busy  = '0;
    m_ovr   = 1'b0;
    m_stall = 0;
  endtask

  task automatic model_update(input stim_t s);
    exp_t e;
    e = predict(s);
    if (s.valid && !e.ready && m_stall < (1 << CW) - 1) m_stall++;
    for (int r = 1; r < RC; r++)
      if (m_busy[r] && m_cyc > m_due[r] && !hit(s, IW'(r))) m_ovr = 1'b1;
    if (s.flush) begin
      m_busy = '0;
    end else begin
      for (int r = 1; r < RC; r++)
        if (m_busy[r] && hit(s, IW'(r))) m_busy[r] = 1'b0;
      if (s.valid && e.ready && s.we && s.rd != '0) begin
        m_busy[s.rd] = 1'b1;
        m_due[s.rd]  = m_cyc + ((s.lat == '0) ? 1 : longint'(s.lat));
      end
    end
    m_cyc++;
  endtask

  task automatic tick();
    q.push_back(predict(cur));
    @(posedge clk);
    model_update(cur);
    #1;
  endtask

  function automatic logic [IW-1:0] rnd_reg();
    return ($urandom_range(0, 4) == 0) ? IW'($urandom_range(0, RC - 1)) : IW'($urandom_range(0, 7));
  endfunction

  function automatic stim_t rnd_stim();
    stim_t s;
    s.valid = ($urandom_range(0, 3) != 0);
    s.rs1   = rnd_reg();
    s.rs2   = rnd_reg();
    s.u1    = 1'($urandom_range(0, 1));
    s.u2    = 1'($urandom_range(0, 1));
    s.v1    = $urandom;
    s.v2    = $urandom;
    s.rd    = rnd_reg();
    s.we    = 1'($urandom_range(0, 1));
    s.lat   = LW'($urandom_range(0, 7));
    s.wbv   = 1'($urandom_range(0, 1));
    s.wbrd  = rnd_reg();
    s.wdata = $urandom;
    s.flush = ($urandom_range(0, 31) == 0);
    return s;
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        check("issue_ready", DW'(issue_ready), DW'(e.ready));
        check("rs1_value", rs1_value, e.v1);
        check("rs2_value", rs2_value, e.v2);
        check("rs1_forwarded", DW'(rs1_forwarded), DW'(e.f1));
        check("rs2_forwarded", DW'(rs2_forwarded), DW'(e.f2));
        check("overrun_error", DW'(overrun_error), DW'(e.ovr));
        check("stall_count", DW'(stall_count), DW'(e.stall));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    stim_t s;
    model_reset();
    #1 rst = 1'b1;
    #1;
    check("reset_ready", DW'(issue_ready), 1);
    check("reset_overrun", DW'(overrun_error), 0);
    check("reset_stall", DW'(stall_count), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Back-to-back dependence on a 1-cycle ALU op.
    s = '0; s.valid = 1; s.we = 1; s.rd = 5; s.lat = 1; cur = s; tick();
    s = '0; s.valid = 1; s.u1 = 1; s.rs1 = 5; s.v1 = 32'hAAAA; cur = s;
    #1 check("alu_raw_stall", DW'(issue_ready), 0);
    s.wbv = 1; s.wbrd = 5; s.wdata = 32'h1234; cur = s;
    #1 check("alu_fwd_ready", DW'(issue_ready), 1);
    check("alu_fwd_value", rs1_value, 32'h1234);
    check("alu_fwd_flag", DW'(rs1_forwarded), 1);
    tick();

    // Load-use with latency 3.
    s = '0; s.valid = 1; s.we = 1; s.rd = 7; s.lat = 3; cur = s; tick();
    s = '0; s.valid = 1; s.u1 = 1; s.rs1 = 7; s.v1 = 32'h1; cur = s;
    #1 check("load_use_t1", DW'(issue_ready), 0);
    tick();
    #1 check("load_use_t2", DW'(issue_ready), 0);
    tick();
    s.wbv = 1; s.wbrd = 7; s.wdata = 32'hBEEF; cur = s;
    #1 check("load_use_t3_ready", DW'(issue_ready), 1);
    check("load_use_t3_value", rs1_value, 32'hBEEF);
    check("load_use_stalls", DW'(stall_count), 2);
    tick();

    // WAW on x9, then x0 never stalls or forwards.
    s = '0; s.valid = 1; s.we = 1; s.rd = 9; s.lat = 2; cur = s; tick();
    cur = s;
    #1 check("waw_stall", DW'(issue_ready), 0);
    tick();
    s.wbv = 1; s.wbrd = 9; s.wdata = 32'h9; cur = s;
    #1 check("waw_release", DW'(issue_ready), 1);
    tick();
    s = '0; s.wbv = 1; s.wbrd = 9; cur = s;
    #1 check("waw_stalls", DW'(stall_count), 3);
    tick();
    s = '0; s.valid = 1; s.we = 1; s.rd = 0; s.u1 = 1; s.rs1 = 0; s.v1 = 32'h55;
    s.u2 = 1; s.rs2 = 0; s.v2 = 32'h66; s.wbv = 1; s.wbrd = 0; s.wdata = 32'hDEAD; cur = s;
    #1 check("x0_ready", DW'(issue_ready), 1);
    check("x0_rs1_value", rs1_value, 32'h55);
    check("x0_rs1_fwd", DW'(rs1_forwarded), 0);
    check("x0_rs2_value", rs2_value, 32'h66);
    tick();
    s = '0; s.valid = 1; s.u1 = 1; s.rs1 = 0; s.v1 = 32'h77; cur = s;
    #1 check("x0_never_busy", DW'(issue_ready), 1);
    tick();

    // Unused operand on a busy register.
    s = '0; s.valid = 1; s.we = 1; s.rd = 11; s.lat = 3; cur = s; tick();
    s = '0; s.valid = 1; s.u1 = 1; s.rs1 = 1; s.rs2 = 11; s.v2 = 32'h22; cur = s;
    #1 check("unused_rs2_ready", DW'(issue_ready), 1);
    s.wbv = 1; s.wbrd = 11; s.wdata = 32'h999; cur = s;
    #1 check("unused_rs2_fwd", DW'(rs2_forwarded), 0);
    check("unused_rs2_value", rs2_value, 32'h22);
    tick();

    // Flush discards tracking.
    s = '0; s.valid = 1; s.we = 1; s.rd = 3; s.lat = 2; cur = s; tick();
    s = '0; s.valid = 1; s.u1 = 1; s.rs1 = 3; s.flush = 1; cur = s;
    #1 check("flush_not_ready", DW'(issue_ready), 0);
    tick();
    s.flush = 0; cur = s;
    #1 check("post_flush_ready", DW'(issue_ready), 1);
    tick();

    // Latency overrun on x4 and stickiness.
    s = '0; s.valid = 1; s.we = 1; s.rd = 4; s.lat = 1; cur = s; tick();
    cur = '0;
    #1 check("overrun_t1", DW'(overrun_error), 0);
    tick();
    #1 check("overrun_t2", DW'(overrun_error), 0);
    tick();
    #1 check("overrun_set", DW'(overrun_error), 1);
    tick();
    tick();
    #1 check("overrun_sticky", DW'(overrun_error), 1);
    tick();

    // Asynchronous reset with registers busy.
    s = '0; s.valid = 1; s.we = 1; s.rd = 6; s.lat = 5; cur = s; tick();
    s.rd = 2; s.lat = 7; cur = s; tick();
    s = '0; s.u1 = 1; s.rs1 = 6; s.u2 = 1; s.rs2 = 2; s.we = 1; s.rd = 4; cur = s;
    #1 check("pre_reset_busy", DW'(issue_ready), 0);
    rst = 1'b1;
    #1 check("async_reset_ready", DW'(issue_ready), 1);
    check("async_reset_overrun", DW'(overrun_error), 0);
    check("async_reset_stall", DW'(stall_count), 0);
    model_reset();
    #1 rst = 1'b0;
    tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cur = rnd_stim();
      tick();
    end

    cur = '0;
    @(negedge clk);
    #1 check("queue_drained", DW'(q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
